urv_dm_arbiter: RTL and testbench

URV_DM_ARBITER -- requirements
Module: urv_dm_arbiter

---
 rtl/urv_dm_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_urv_dm_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_dm_arbiter.sv
// urv_dm_arbiter: shares one data-memory port between the CPU (single-cycle
// request pulses, one pending slot) and the debug port (level requests held
// until ack). Starvation guard for debug and a completion timeout.
module urv_dm_arbiter #(
    parameter int unsigned g_max_wait = 4,
    parameter int unsigned g_timeout  = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    // CPU port
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_s_i,
    input  logic [3:0]  cpu_select_i,
    input  logic        cpu_load_i,
    input  logic        cpu_store_i,
    output logic        cpu_stall_req_o,
    output logic [31:0] cpu_data_l_o,
    output logic        cpu_load_done_o,
    output logic        cpu_store_done_o,
    // Debug port
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_data_s_i,
    input  logic [3:0]  dbg_select_i,
    input  logic        dbg_load_i,
    input  logic        dbg_store_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_data_l_o,
    // Memory port
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_data_s_o,
    output logic [3:0]  dm_data_select_o,
    output logic        dm_load_o,
    output logic        dm_store_o,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    input  logic        dm_store_done_i,
    // Sticky error
    output logic        bus_err_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_CPU_BUSY, ST_DBG_BUSY} state_t;

    state_t      state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic [3:0]  pend_sel_q, pend_sel_d;
    logic        pend_store_q, pend_store_d;
    logic        flight_store_q, flight_store_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [9:0]  busy_cnt_q, busy_cnt_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_data_s_q, dm_data_s_d;
    logic [3:0]  dm_sel_q, dm_sel_d;
    logic        dm_load_q, dm_load_d;
    logic        dm_store_q, dm_store_d;
    logic [31:0] cpu_data_l_q, cpu_data_l_d;
    logic        cpu_load_done_q, cpu_load_done_d;
    logic        cpu_store_done_q, cpu_store_done_d;
    logic        dbg_ack_q, dbg_ack_d;
    logic [31:0] dbg_data_l_q, dbg_data_l_d;
    logic        bus_err_q, bus_err_d;

    logic cpu_pulse, stall, dbg_req, dbg_first, dbg_grant, done_ok, timed_out;

    assign cpu_pulse = cpu_load_i | cpu_store_i;
    assign stall     = pend_valid_q | (state_q == ST_CPU_BUSY) | (cpu_pulse & (state_q != ST_IDLE));
    // The requester sees the ack in the cycle it is high and drops its level
    // afterwards, so the still-high request in that cycle is not a new one.
    assign dbg_req   = (dbg_load_i | dbg_store_i) & ~dbg_ack_q;
    assign dbg_first = dbg_req & (wait_cnt_q == 8'(g_max_wait));

    // Arbitration, issue, completion/timeout and starvation counting.
    always_comb begin
        state_d          = state_q;
        pend_valid_d     = pend_valid_q;
        pend_addr_d      = pend_addr_q;
        pend_data_d      = pend_data_q;
        pend_sel_d       = pend_sel_q;
        pend_store_d     = pend_store_q;
        flight_store_d   = flight_store_q;
        wait_cnt_d       = wait_cnt_q;
        busy_cnt_d       = busy_cnt_q;
        dm_addr_d        = dm_addr_q;
        dm_data_s_d      = dm_data_s_q;
        dm_sel_d         = dm_sel_q;
        dm_load_d        = 1'b0;
        dm_store_d       = 1'b0;
        cpu_data_l_d     = cpu_data_l_q;
        cpu_load_done_d  = 1'b0;
        cpu_store_done_d = 1'b0;
        dbg_ack_d        = 1'b0;
        dbg_data_l_d     = dbg_data_l_q;
        bus_err_d        = bus_err_q;
        dbg_grant        = 1'b0;
        done_ok          = 1'b0;
        timed_out        = 1'b0;

        if (cpu_pulse && stall)
            bus_err_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if ((pend_valid_q || cpu_pulse) && !dbg_first) begin
                    state_d    = ST_CPU_BUSY;
                    busy_cnt_d = '0;
                    if (pend_valid_q) begin
                        pend_valid_d   = 1'b0;
                        dm_addr_d      = pend_addr_q;
                        dm_data_s_d    = pend_data_q;
                        dm_sel_d       = pend_sel_q;
                        dm_store_d     = pend_store_q;
                        dm_load_d      = ~pend_store_q;
                        flight_store_d = pend_store_q;
                    end else begin
                        dm_addr_d      = cpu_addr_i;
                        dm_data_s_d    = cpu_data_s_i;
                        dm_sel_d       = cpu_select_i;
                        dm_store_d     = cpu_store_i;
                        dm_load_d      = ~cpu_store_i;
                        flight_store_d = cpu_store_i;
                    end
                end else if (dbg_req) begin
                    dbg_grant      = 1'b1;
                    state_d        = ST_DBG_BUSY;
                    busy_cnt_d     = '0;
                    dm_addr_d      = dbg_addr_i;
                    dm_data_s_d    = dbg_data_s_i;
                    dm_sel_d       = dbg_select_i;
                    dm_load_d      = dbg_load_i;
                    dm_store_d     = ~dbg_load_i;
                    flight_store_d = ~dbg_load_i;
                    if (cpu_pulse && !stall) begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = cpu_addr_i;
                        pend_data_d  = cpu_data_s_i;
                        pend_sel_d   = cpu_select_i;
                        pend_store_d = cpu_store_i;
                    end
                end
            end
            ST_CPU_BUSY, ST_DBG_BUSY: begin
                // Done is not accepted while the issue strobe is still on the bus.
                done_ok   = !(dm_load_q || dm_store_q) &&
                            (flight_store_q ? dm_store_done_i : dm_load_done_i);
                timed_out = !done_ok && (busy_cnt_q == 10'(g_timeout - 1));
                if (done_ok || timed_out) begin
                    state_d = ST_IDLE;
                    if (timed_out)
                        bus_err_d = 1'b1;
                    if (state_q == ST_CPU_BUSY) begin
                        if (flight_store_q) begin
                            cpu_store_done_d = 1'b1;
                        end else begin
                            cpu_load_done_d = 1'b1;
                            cpu_data_l_d    = timed_out ? '0 : dm_data_l_i;
                        end
                    end else begin
                        dbg_ack_d = 1'b1;
                        if (!flight_store_q)
                            dbg_data_l_d = timed_out ? '0 : dm_data_l_i;
                    end
                end else begin
                    busy_cnt_d = busy_cnt_q + 10'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (dbg_grant)
            wait_cnt_d = '0;
        else if (dbg_req && (state_q != ST_DBG_BUSY) && (wait_cnt_q < 8'(g_max_wait)))
            wait_cnt_d = wait_cnt_q + 8'd1;
    end

    // State and registered outputs; reset abandons any transaction silently.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= ST_IDLE;
            pend_valid_q     <= 1'b0;
            pend_addr_q      <= '0;
            pend_data_q      <= '0;
            pend_sel_q       <= '0;
            pend_store_q     <= 1'b0;
            flight_store_q   <= 1'b0;
            wait_cnt_q       <= '0;
            busy_cnt_q       <= '0;
            dm_addr_q        <= '0;
            dm_data_s_q      <= '0;
            dm_sel_q         <= '0;
            dm_load_q        <= 1'b0;
            dm_store_q       <= 1'b0;
            cpu_data_l_q     <= '0;
            cpu_load_done_q  <= 1'b0;
            cpu_store_done_q <= 1'b0;
            dbg_ack_q        <= 1'b0;
            dbg_data_l_q     <= '0;
            bus_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            pend_valid_q     <= pend_valid_d;
            pend_addr_q      <= pend_addr_d;
            pend_data_q      <= pend_data_d;
            pend_sel_q       <= pend_sel_d;
            pend_store_q     <= pend_store_d;
            flight_store_q   <= flight_store_d;
            wait_cnt_q       <= wait_cnt_d;
            busy_cnt_q       <= busy_cnt_d;
            dm_addr_q        <= dm_addr_d;
            dm_data_s_q      <= dm_data_s_d;
            dm_sel_q         <= dm_sel_d;
            dm_load_q        <= dm_load_d;
            dm_store_q       <= dm_store_d;
            cpu_data_l_q     <= cpu_data_l_d;
            cpu_load_done_q  <= cpu_load_done_d;
            cpu_store_done_q <= cpu_store_done_d;
            dbg_ack_q        <= dbg_ack_d;
            dbg_data_l_q     <= dbg_data_l_d;
            bus_err_q        <= bus_err_d;
        end
    end

    assign cpu_stall_req_o  = stall;
    assign cpu_data_l_o     = cpu_data_l_q;
    assign cpu_load_done_o  = cpu_load_done_q;
    assign cpu_store_done_o = cpu_store_done_q;
    assign dbg_ack_o        = dbg_ack_q;
    assign dbg_data_l_o     = dbg_data_l_q;
    assign dm_addr_o        = dm_addr_q;
    assign dm_data_s_o      = dm_data_s_q;
    assign dm_data_select_o = dm_sel_q;
    assign dm_load_o        = dm_load_q;
    assign dm_store_o       = dm_store_q;
    assign bus_err_o        = bus_err_q;

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Directed bench for urv_dm_arbiter: a per-cycle vector table plus hand
// sequences for reset mid-transaction and the completion timeout.
module tb_urv_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_data_s = 32'hC0DE_0000;
    logic [3:0]  cpu_sel = 4'hF;
    logic        cpu_load = 1'b0, cpu_store = 1'b0;
    logic        cpu_stall;
    logic [31:0] cpu_data_l;
    logic        cpu_load_done, cpu_store_done;
    logic [31:0] dbg_addr = '0, dbg_data_s = 32'hDB60_0000;
    logic [3:0]  dbg_sel = 4'h3;
    logic        dbg_load = 1'b0, dbg_store = 1'b0;
    logic        dbg_ack;
    logic [31:0] dbg_data_l;
    logic [31:0] dm_addr, dm_data_s;
    logic [3:0]  dm_sel;
    logic        dm_load, dm_store;
    logic [31:0] dm_data_l = '0;
    logic        dm_load_done = 1'b0, dm_store_done = 1'b0;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    urv_dm_arbiter #(.g_max_wait(4), .g_timeout(64)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cpu_addr_i(cpu_addr), .cpu_data_s_i(cpu_data_s), .cpu_select_i(cpu_sel),
        .cpu_load_i(cpu_load), .cpu_store_i(cpu_store),
        .cpu_stall_req_o(cpu_stall), .cpu_data_l_o(cpu_data_l),
        .cpu_load_done_o(cpu_load_done), .cpu_store_done_o(cpu_store_done),
        .dbg_addr_i(dbg_addr), .dbg_data_s_i(dbg_data_s), .dbg_select_i(dbg_sel),
        .dbg_load_i(dbg_load), .dbg_store_i(dbg_store),
        .dbg_ack_o(dbg_ack), .dbg_data_l_o(dbg_data_l),
        .dm_addr_o(dm_addr), .dm_data_s_o(dm_data_s), .dm_data_select_o(dm_sel),
        .dm_load_o(dm_load), .dm_store_o(dm_store),
        .dm_data_l_i(dm_data_l), .dm_load_done_i(dm_load_done), .dm_store_done_i(dm_store_done),
        .bus_err_o(bus_err)
    );

    always #5 clk = ~clk;

    // ctl = {cpu_load, cpu_store, dbg_load, dbg_store}; dn = {load_done, store_done}
    // ef  = {stall, dm_load, dm_store, cpu_load_done, cpu_store_done, dbg_ack, bus_err}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] ca;
        logic [31:0] da;
        logic [1:0]  dn;
        logic [31:0] ml;
        logic [6:0]  ef;
        logic [31:0] ea;
        logic [3:0]  es;
        logic [31:0] ecdl;
        logic [31:0] eddl;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] ctl, input logic [31:0] ca, input logic [31:0] da,
                       input logic [1:0] dn, input logic [31:0] ml, input logic [6:0] ef,
                       input logic [31:0] ea, input logic [3:0] es,
                       input logic [31:0] ecdl, input logic [31:0] eddl);
        vec_t v;
        v.ctl = ctl; v.ca = ca; v.da = da; v.dn = dn; v.ml = ml;
        v.ef = ef; v.ea = ea; v.es = es; v.ecdl = ecdl; v.eddl = eddl;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_dm_load"}, dm_load, 1'b0);
        chk1({tag, "_dm_store"}, dm_store, 1'b0);
        chk({tag, "_dm_addr"}, dm_addr, 32'h0);
        chk({tag, "_dm_data_s"}, dm_data_s, 32'h0);
        chk({tag, "_dm_sel"}, {28'h0, dm_sel}, 32'h0);
        chk({tag, "_cpu_data_l"}, cpu_data_l, 32'h0);
        chk1({tag, "_cpu_load_done"}, cpu_load_done, 1'b0);
        chk1({tag, "_cpu_store_done"}, cpu_store_done, 1'b0);
        chk1({tag, "_dbg_ack"}, dbg_ack, 1'b0);
        chk({tag, "_dbg_data_l"}, dbg_data_l, 32'h0);
        chk1({tag, "_bus_err"}, bus_err, 1'b0);
        chk1({tag, "_stall"}, cpu_stall, 1'b0);
    endtask

    initial begin
        int found;

        // Vector table, one row per clock cycle.
        // CPU load 0x100, early done ignored, completion at +3.
        add(4'b1000, 32'h100, 32'h0,   2'b00, 32'h0,         7'b0100000, 32'h100, 4'hF, 32'h0,         32'h0);
        add(4'b0000, 32'h0,   32'h0,   2'b10, 32'hDEAD_BEEF, 7'b1000000, 32'h100, 4'hF, 32'h0,         32'h0);
        add(4'b0000, 32'h0,   32'h0,   2'b10, 32'hA5A5_0001, 7'b1001000, 32'h100, 4'hF, 32'hA5A5_0001, 32'h0);
        add(4'b0000, 32'h0,   32'h0,   2'b00, 32'h0,         7'b0000000, 32'h100, 4'hF, 32'hA5A5_0001, 32'h0);
        // Simultaneous CPU/debug store: CPU first, mismatched done ignored, then debug, one ack.
        add(4'b0101, 32'h200, 32'h300, 2'b00, 32'h0,         7'b0010000, 32'h200, 4'hF, 32'hA5A5_0001, 32'h0);
        add(4'b0001, 32'h0,   32'h300, 2'b10, 32'hBAD0_BAD0, 7'b1000000, 32'h200, 4'hF, 32'hA5A5_0001, 32'h0);
        add(4'b0001, 32'h0,   32'h300, 2'b01, 32'h0,         7'b1000100, 32'h200, 4'hF, 32'hA5A5_0001, 32'h0);
        add(4'b0001, 32'h0,   32'h300, 2'b00, 32'h0,         7'b0010000, 32'h300, 4'h3, 32'hA5A5_0001, 32'h0);
        add(4'b0001, 32'h0,   32'h300, 2'b00, 32'h0,         7'b0000000, 32'h300, 4'h3, 32'hA5A5_0001, 32'h0);
        add(4'b0001, 32'h0,   32'h300, 2'b01, 32'h0,         7'b0000010, 32'h300, 4'h3, 32'hA5A5_0001, 32'h0);
        add(4'b0001, 32'h0,   32'h300, 2'b00, 32'h0,         7'b0000000, 32'h300, 4'h3, 32'hA5A5_0001, 32'h0);
        add(4'b0000, 32'h0,   32'h0,   2'b00, 32'h0,         7'b0000000, 32'h300, 4'h3, 32'hA5A5_0001, 32'h0);
        // CPU pulse while stalled: dropped, sticky error.
        add(4'b1000, 32'h400, 32'h0,   2'b00, 32'h0,         7'b0100000, 32'h400, 4'hF, 32'hA5A5_0001, 32'h0);
        add(4'b1000, 32'h500, 32'h0,   2'b00, 32'h0,         7'b1000001, 32'h400, 4'hF, 32'hA5A5_0001, 32'h0);
        add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h1111_2222, 7'b1001001, 32'h400, 4'hF, 32'h1111_2222, 32'h0);
        add(4'b0000, 32'h0,   32'h0,   2'b00, 32'h0,         7'b0000001, 32'h400, 4'hF, 32'h1111_2222, 32'h0);
        // Back-to-back CPU loads, debug load held: debug wins once wait reaches 4.
        add(4'b1010, 32'h700, 32'h600, 2'b00, 32'h0,         7'b0100001, 32'h700, 4'hF, 32'h1111_2222, 32'h0);
        add(4'b0010, 32'h0,   32'h600, 2'b00, 32'h0,         7'b1000001, 32'h700, 4'hF, 32'h1111_2222, 32'h0);
        add(4'b0010, 32'h0,   32'h600, 2'b10, 32'h70,        7'b1001001, 32'h700, 4'hF, 32'h70,        32'h0);
        add(4'b1010, 32'h704, 32'h600, 2'b00, 32'h0,         7'b0100001, 32'h704, 4'hF, 32'h70,        32'h0);
        add(4'b0010, 32'h0,   32'h600, 2'b00, 32'h0,         7'b1000001, 32'h704, 4'hF, 32'h70,        32'h0);
        add(4'b0010, 32'h0,   32'h600, 2'b10, 32'h74,        7'b1001001, 32'h704, 4'hF, 32'h74,        32'h0);
        add(4'b1010, 32'h708, 32'h600, 2'b00, 32'h0,         7'b0100001, 32'h600, 4'h3, 32'h74,        32'h0);
        add(4'b0010, 32'h0,   32'h600, 2'b00, 32'h0,         7'b1000001, 32'h600, 4'h3, 32'h74,        32'h0);
        add(4'b0010, 32'h0,   32'h600, 2'b10, 32'hDB0,       7'b1000011, 32'h600, 4'h3, 32'h74,        32'hDB0);
        add(4'b0000, 32'h0,   32'h0,   2'b00, 32'h0,         7'b1100001, 32'h708, 4'hF, 32'h74,        32'hDB0);
        add(4'b0000, 32'h0,   32'h0,   2'b00, 32'h0,         7'b1000001, 32'h708, 4'hF, 32'h74,        32'hDB0);
        add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h78,        7'b1001001, 32'h708, 4'hF, 32'h78,        32'hDB0);
        add(4'b0000, 32'h0,   32'h0,   2'b00, 32'h0,         7'b0000001, 32'h708, 4'hF, 32'h78,        32'hDB0);
        // Debug request withdrawn before grant: no issue, no ack.
        add(4'b1010, 32'h800, 32'h900, 2'b00, 32'h0,         7'b0100001, 32'h800, 4'hF, 32'h78,        32'hDB0);
        add(4'b0000, 32'h0,   32'h0,   2'b00, 32'h0,         7'b1000001, 32'h800, 4'hF, 32'h78,        32'hDB0);
        add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h80,        7'b1001001, 32'h800, 4'hF, 32'h80,        32'hDB0);
        add(4'b0000, 32'h0,   32'h0,   2'b00, 32'h0,         7'b0000001, 32'h800, 4'hF, 32'h80,        32'hDB0);

        // Reset state.
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            {cpu_load, cpu_store, dbg_load, dbg_store} = vq[i].ctl;
            cpu_addr = vq[i].ca;
            dbg_addr = vq[i].da;
            {dm_load_done, dm_store_done} = vq[i].dn;
            dm_data_l = vq[i].ml;
            #1;
            chk1($sformatf("r%0d_stall", i), cpu_stall, vq[i].ef[6]);
            @(posedge clk);
            #1;
            chk1($sformatf("r%0d_dm_load", i), dm_load, vq[i].ef[5]);
            chk1($sformatf("r%0d_dm_store", i), dm_store, vq[i].ef[4]);
            chk1($sformatf("r%0d_cpu_load_done", i), cpu_load_done, vq[i].ef[3]);
            chk1($sformatf("r%0d_cpu_store_done", i), cpu_store_done, vq[i].ef[2]);
            chk1($sformatf("r%0d_dbg_ack", i), dbg_ack, vq[i].ef[1]);
            chk1($sformatf("r%0d_bus_err", i), bus_err, vq[i].ef[0]);
            chk($sformatf("r%0d_dm_addr", i), dm_addr, vq[i].ea);
            chk($sformatf("r%0d_dm_sel", i), {28'h0, dm_sel}, {28'h0, vq[i].es});
            chk($sformatf("r%0d_cpu_data_l", i), cpu_data_l, vq[i].ecdl);
            chk($sformatf("r%0d_dbg_data_l", i), dbg_data_l, vq[i].eddl);
            if (vq[i].ef[5] || vq[i].ef[4])
                chk($sformatf("r%0d_dm_data_s", i), dm_data_s,
                    (vq[i].es == 4'h3) ? 32'hDB60_0000 : 32'hC0DE_0000);
        end

        // Reset in the middle of a CPU transaction.
        @(negedge clk);
        {cpu_load, cpu_store, dbg_load, dbg_store} = 4'b1000;
        cpu_addr = 32'hB00;
        {dm_load_done, dm_store_done} = 2'b00;
        @(posedge clk);
        #1;
        chk1("rst_pre_dm_load", dm_load, 1'b1);
        @(negedge clk);
        cpu_load = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        dm_load_done = 1'b1;
        dm_data_l = 32'h123;
        @(posedge clk);
        #1;
        chk1("rst_no_done", cpu_load_done, 1'b0);
        @(negedge clk);
        dm_load_done = 1'b0;
        rst_n = 1'b1;
        cpu_load = 1'b1;
        cpu_addr = 32'hC00;
        @(posedge clk);
        #1;
        chk1("post_rst_dm_load", dm_load, 1'b1);
        chk("post_rst_dm_addr", dm_addr, 32'hC00);
        chk1("post_rst_no_done", cpu_load_done, 1'b0);
        @(negedge clk);
        cpu_load = 1'b0;
        @(negedge clk);
        dm_load_done = 1'b1;
        dm_data_l = 32'hCCC;
        @(posedge clk);
        #1;
        chk1("post_rst_load_done", cpu_load_done, 1'b1);
        chk("post_rst_data", cpu_data_l, 32'hCCC);
        chk1("post_rst_err", bus_err, 1'b0);
        @(negedge clk);
        dm_load_done = 1'b0;

        // Timeout: memory never answers.
        cpu_load = 1'b1;
        cpu_addr = 32'hD00;
        dm_data_l = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk1("to_dm_load", dm_load, 1'b1);
        @(negedge clk);
        cpu_load = 1'b0;
        found = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (cpu_load_done) begin
                found = k;
                break;
            end
            if (k == 63)
                chk1("to_err_before", bus_err, 1'b0);
        end
        chk("to_latency", found, 64);
        chk("to_data", cpu_data_l, 32'h0);
        chk1("to_err", bus_err, 1'b1);
        @(negedge clk);
        cpu_load = 1'b1;
        cpu_addr = 32'hE00;
        @(posedge clk);
        #1;
        chk1("to_idle_dm_load", dm_load, 1'b1);
        chk("to_idle_dm_addr", dm_addr, 32'hE00);
        chk1("to_err_sticky", bus_err, 1'b1);
        @(negedge clk);
        cpu_load = 1'b0;
        @(posedge clk);
        #1;
        chk1("to_err_sticky2", bus_err, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
